seg_display_sched: RTL and testbench

- Schedules values written by the core onto the shared 7-segment output pins.
- Buffers writes in a small FIFO and presents each entry on the segments for a programmable dwell time.
- Lets software emit digit sequences, e.g. a multi-digit result, on the single 7-segment display without busy-waiting.
- Sits between the core's output write port and the top-level segment outputs.

---
 rtl/seg_display_sched.sv | 217 +++++++++++++++++++++
 tb/tb_seg_display_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
// seg_display_sched: FIFO-buffered scheduler for the 7-segment pins.
// Each queued entry is shown for max(dwell,1) cycles.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - async reset, active-low
//   wr_valid - core presents an entry
//   wr_ready - FIFO can accept (!full)
//   wr_data  - bit7=1 raw [6:0], else hex digit [3:0]
//   dwell    - display cycles, sampled at load
//   level    - FIFO occupancy
//   busy     - not idle or FIFO non-empty
//   segments - bit0=a .. bit6=g, registered
//
// Build option: define SEG_GAP_EN to blank the
// display for GAP_CYCLES cycles between queued
// digits.
module seg_display_sched #(
  parameter int DEPTH      = 4,
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_data,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [6:0]             segments
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
`ifdef SEG_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam int GW = $clog2(GAP_CYCLES + 1);
`endif

  logic [7:0]         mem_q [DEPTH];
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [AW:0]        lvl_q;
  logic [AW:0]        lvl_d;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [DWELL_W-1:0] dwc_q;
  logic [DWELL_W-1:0] dwc_d;
  logic [6:0]         seg_q;
  logic [6:0]         seg_d;
`ifdef SEG_GAP_EN
  logic [GW-1:0]      gap_q;
  logic [GW-1:0]      gap_d;
`endif

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [7:0]         head;
  logic [6:0]         head_seg;
  logic [DWELL_W-1:0] dwell_m1;

  function automatic logic [6:0] decode(
    input logic [7:0] e
  );
    logic [6:0] s;
    if (e[7]) begin
      s = e[6:0];
    end else begin
      case (e[3:0])
        4'h0:    s = 7'h3F;
        4'h1:    s = 7'h06;
        4'h2:    s = 7'h5B;
        4'h3:    s = 7'h4F;
        4'h4:    s = 7'h66;
        4'h5:    s = 7'h6D;
        4'h6:    s = 7'h7D;
        4'h7:    s = 7'h07;
        4'h8:    s = 7'h7F;
        4'h9:    s = 7'h6F;
        4'hA:    s = 7'h77;
        4'hB:    s = 7'h7C;
        4'hC:    s = 7'h39;
        4'hD:    s = 7'h5E;
        4'hE:    s = 7'h79;
        default: s = 7'h71;
      endcase
    end
    return s;
  endfunction

  // Full blocks writes even when a pop
  // happens in the same cycle.
  assign full     = (lvl_q == (AW+1)'(DEPTH));
  assign empty    = (lvl_q == '0);
  assign push     = wr_valid & ~full;
  assign wr_ready = ~full;
  assign level    = lvl_q;
  assign segments = seg_q;
  assign busy     = (state_q != S_IDLE) | ~empty;

  assign head     = mem_q[rptr_q];
  assign head_seg = decode(head);

  // Counter holds remaining cycles minus one,
  // so dwell=0 shows for one cycle.
  assign dwell_m1 = (dwell == '0) ? '0
                  : dwell - 1'b1;

  always_comb begin
    state_d = state_q;
    dwc_d   = dwc_q;
    seg_d   = seg_q;
    pop     = 1'b0;
`ifdef SEG_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          seg_d   = head_seg;
          dwc_d   = dwell_m1;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (dwc_q != '0) begin
          dwc_d = dwc_q - 1'b1;
        end else if (!empty) begin
`ifdef SEG_GAP_EN
          seg_d   = 7'h00;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = S_GAP;
`else
          pop     = 1'b1;
          seg_d   = head_seg;
          dwc_d   = dwell_m1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef SEG_GAP_EN
      // Entries only leave via pop, so the
      // FIFO is still non-empty here.
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          pop     = 1'b1;
          seg_d   = head_seg;
          dwc_d   = dwell_m1;
          state_d = S_SHOW;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    lvl_d = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Storage needs no reset: level and
  // pointers define which words are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      state_q <= S_IDLE;
      dwc_q   <= '0;
      seg_q   <= 7'h00;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      lvl_q   <= lvl_d;
      state_q <= state_d;
      dwc_q   <= dwc_d;
      seg_q   <= seg_d;
    end
  end

`ifdef SEG_GAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: random + directed bench
// against a queue-based timing model.
module tb_seg_display_sched;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int GAP   = 2;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [7:0] dwell;
  logic [2:0] level;
  logic       busy;
  logic [6:0] segments;

  seg_display_sched #(
    .DEPTH(DEPTH),
    .DWELL_W(DW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .dwell(dwell),
    .level(level),
    .busy(busy),
    .segments(segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: pending entries, cycles left on
  // the current entry, blank cycles left.
  logic [7:0] q [$];
  int         remain;
  int         gap_left;
  logic [6:0] m_seg;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] decode(
    input logic [7:0] e
  );
    if (e[7]) return e[6:0];
    return hex_tab[e[3:0]];
  endfunction

  task automatic model_reset();
    q.delete();
    remain   = 0;
    gap_left = 0;
    m_seg    = 7'h00;
  endtask

  task automatic model_edge();
    int sz;
    bit acc;
    bit ld;
    sz  = q.size();
    acc = wr_valid && (sz < DEPTH);
    ld  = 0;
    if (gap_left > 0) begin
      gap_left--;
      if (gap_left == 0) ld = 1;
    end else if (remain > 1) begin
      remain--;
    end else if (sz > 0) begin
`ifdef SEG_GAP_EN
      if (remain == 1) begin
        remain   = 0;
        gap_left = GAP;
        m_seg    = 7'h00;
      end else begin
        ld = 1;
      end
`else
      ld = 1;
`endif
    end else begin
      remain = 0;
    end
    if (ld) begin
      m_seg  = decode(q.pop_front());
      remain = (dwell == 0) ? 1 : int'(dwell);
    end
    if (acc) q.push_back(wr_data);
  endtask

  task automatic check_outs(input string tag);
    check({tag, " seg"}, 32'(segments), 32'(m_seg));
    check({tag, " level"}, 32'(level),
          32'(q.size()));
    check({tag, " ready"}, 32'(wr_ready),
          32'(q.size() < DEPTH));
    check({tag, " busy"}, 32'(busy),
          32'(remain > 0 || gap_left > 0 ||
              q.size() > 0));
  endtask

  task automatic cycle(
    input logic       v,
    input logic [7:0] d,
    input logic [7:0] dw
  );
    wr_valid = v;
    wr_data  = d;
    dwell    = dw;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_outs("cyc");
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && busy; i++)
      cycle(1'b0, 8'h00, 8'd1);
    check("drain busy", 32'(busy), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h05;
    dwell    = 8'd3;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("rst seg", 32'(segments), 32'h00);
    check("rst level", 32'(level), 32'h0);
    check("rst ready", 32'(wr_ready), 32'h1);
    check("rst busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'h05, 8'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 8'h00, 8'd3);
    check("idle seg", 32'(segments), 32'h00);

    // single hex digit, dwell 3
    cycle(1'b1, 8'h05, 8'd3);
    cycle(1'b0, 8'h00, 8'd3);
    check("hex5 seg", 32'(segments), 32'h6D);
    check("hex5 busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 8'h00, 8'd3);
    check("hold seg", 32'(segments), 32'h6D);
    check("hold busy", 32'(busy), 32'h0);

    // burst back-to-back, dwell 2
    cycle(1'b1, 8'h01, 8'd2);
    cycle(1'b1, 8'h02, 8'd2);
    cycle(1'b1, 8'h03, 8'd2);
    cycle(1'b1, 8'h0A, 8'd2);
    drain();
    check("burst last", 32'(segments), 32'h77);

    // fill to full with a long dwell
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'(i), 8'd20);
    check("full level", 32'(level), 32'h4);
    check("full ready", 32'(wr_ready), 32'h0);
    cycle(1'b1, 8'h0E, 8'd20);
    check("drop level", 32'(level), 32'h4);
    drain();

    // raw then hex, dwell 0
    cycle(1'b1, 8'hC9, 8'd0);
    cycle(1'b1, 8'h0F, 8'd0);
    check("raw seg", 32'(segments), 32'h49);
    cycle(1'b0, 8'h00, 8'd0);
`ifndef SEG_GAP_EN
    check("hexF seg", 32'(segments), 32'h71);
`endif
    drain();

`ifdef SEG_GAP_EN
    cycle(1'b1, 8'h08, 8'd2);
    cycle(1'b1, 8'h08, 8'd2);
    check("gap a", 32'(segments), 32'h7F);
    cycle(1'b0, 8'h00, 8'd2);
    cycle(1'b0, 8'h00, 8'd2);
    check("gap b", 32'(segments), 32'h00);
    cycle(1'b0, 8'h00, 8'd2);
    cycle(1'b0, 8'h00, 8'd2);
    check("gap c", 32'(segments), 32'h7F);
    drain();
    check("gap hold", 32'(segments), 32'h7F);
`endif

    // reset mid-show with entries queued
    cycle(1'b1, 8'h03, 8'd10);
    cycle(1'b1, 8'h04, 8'd10);
    cycle(1'b1, 8'h06, 8'd10);
    cycle(1'b0, 8'h00, 8'd10);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("arst seg", 32'(segments), 32'h00);
    check("arst level", 32'(level), 32'h0);
    check("arst busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 8'h00, 8'd1);
    check("post seg", 32'(segments), 32'h00);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic       v;
      logic [7:0] d;
      logic [7:0] dw;
      v  = ($urandom_range(0, 99) < 45);
      d  = 8'($urandom);
      dw = 8'($urandom_range(0, 4));
      cycle(v, d, dw);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
